// File: rtl/bcd_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bcd_serial_adder_ctrl
// Description : Digit-serial packed-BCD adder, one decimal digit per cycle, LSD first.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cin,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int c_idx_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [4*DIGITS-1:0]  r_a;
    logic [4*DIGITS-1:0]  r_b;
    logic                 r_c;
    logic [c_idx_w-1:0]   r_idx;
    logic [4*DIGITS-1:0]  r_sum;
    logic                 r_cout;
    logic                 r_err;

    logic [3:0]           w_a_dig;
    logic [3:0]           w_b_dig;
    logic [4:0]           w_t;
    logic [3:0]           w_dig;
    logic                 w_c;
    logic                 w_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ADD;
            S_ADD:   if (r_idx == c_last_idx) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Shared digit adder; the (t+6) mod 16 correction only needs the low nibble of t.
    always_comb begin
        w_a_dig = r_a[{r_idx, 2'b00} +: 4];
        w_b_dig = r_b[{r_idx, 2'b00} +: 4];
        w_t     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, r_c};
        w_dig   = w_t[3:0];
        w_c     = 1'b0;
        if (w_t > 5'd9) begin
            w_dig = w_t[3:0] + 4'd6;
            w_c   = 1'b1;
        end
    end

    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) begin
                w_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_c    <= cin;
                        r_idx  <= '0;
                        r_sum  <= '0;
                        r_cout <= 1'b0;
                        r_err  <= w_err;
                    end
                end
                S_ADD: begin
                    r_sum[{r_idx, 2'b00} +: 4] <= w_dig;
                    r_c <= w_c;
                    if (r_idx == c_last_idx) begin
                        r_cout <= w_c;
                        r_idx  <= '0;
                    end else begin
                        r_idx <= r_idx + c_idx_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_serial_adder_ctrl
// Description : Scoreboard bench for the digit-serial BCD adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_adder_ctrl;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         cin   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic         err;
    logic [W-1:0] sum;

    bcd_serial_adder_ctrl #(.DIGITS(D)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         er;
        int           dc;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc     = 0;
    int           free_at = 0;
    int           total   = 0;
    int           bad     = 0;
    logic [W-1:0] last_s  = '0;
    logic         last_co = 1'b0;
    logic         last_er = 1'b0;

    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", n, cyc, act, expv);
        end
    endtask

    // Decimal digit-by-digit addition straight from the arithmetic rule.
    function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        exp_t r;
        int   c;
        c    = ci ? 1 : 0;
        r.s  = '0;
        r.er = 1'b0;
        r.dc = 0;
        for (int i = 0; i < D; i++) begin
            logic [3:0] xd;
            logic [3:0] yd;
            int         t;
            xd = x[4*i +: 4];
            yd = y[4*i +: 4];
            if (xd > 4'd9 || yd > 4'd9) r.er = 1'b1;
            t = int'(xd) + int'(yd) + c;
            if (t > 9) begin
                r.s[4*i +: 4] = 4'((t + 6) % 16);
                c = 1;
            end else begin
                r.s[4*i +: 4] = 4'(t);
                c = 0;
            end
        end
        r.co = (c != 0);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_bcd(input bit allow_bad);
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < D; i++) begin
            if (allow_bad && $urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
            else                                       v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // Protocol model: a request is taken when start is seen at an edge where the block is free.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                free_at = cyc + 1;
                exp_q.delete();
                last_s  = '0;
                last_co = 1'b0;
                last_er = 1'b0;
            end else if (start && cyc >= free_at) begin
                e    = ref_model(a, b, cin);
                e.dc = cyc + D;
                exp_q.push_back(e);
                free_at = cyc + D + 2;
            end
        end
    end

    // Monitor
    initial begin
        exp_t h;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                chk("busy", W'(busy), W'(cyc < free_at - 1));
                if (done) begin
                    if (exp_q.size() == 0) begin
                        chk("done_unexpected", W'(done), '0);
                    end else begin
                        h = exp_q.pop_front();
                        chk("done_cycle", W'(cyc), W'(h.dc));
                        chk("sum", sum, h.s);
                        chk("cout", W'(cout), W'(h.co));
                        chk("err", W'(err), W'(h.er));
                        last_s  = h.s;
                        last_co = h.co;
                        last_er = h.er;
                    end
                end else if (exp_q.size() > 0 && exp_q[0].dc <= cyc) begin
                    chk("done_missing", W'(done), W'(1));
                    h = exp_q.pop_front();
                end
                if (!(cyc < free_at - 1)) begin
                    chk("idle_sum", sum, last_s);
                    chk("idle_cout", W'(cout), W'(last_co));
                    chk("idle_err", W'(err), W'(last_er));
                    chk("idle_done", W'(done), '0);
                end
            end
        end
    end

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        @(negedge clk);
        a     = x;
        b     = y;
        cin   = ci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        repeat (D + 2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        op(16'h1234, 16'h5678, 1'b0);
        op(16'h9999, 16'h0001, 1'b0);
        op(16'h0000, 16'h0000, 1'b1);
        op(16'h00A0, 16'h0000, 1'b0);
        op(16'h9999, 16'h9999, 1'b1);

        for (int i = 0; i < 20; i++) begin
            op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom));
        end

        // Start held high with fresh operands every cycle.
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a   = rand_bcd(1'b1);
            b   = rand_bcd(1'b1);
            cin = 1'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (D + 3) @(negedge clk);

        // Reset two edges after acceptance aborts the operation.
        a     = 16'h1111;
        b     = 16'h2222;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (D + 3) @(negedge clk);

        op(16'h4567, 16'h0455, 1'b1);
        repeat (3) @(negedge clk);

        chk("queue_drained", W'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
